// File: rtl/dmem_port_arbiter_pkg.sv
// Shared widths, owner encodings and reset constants for the data-memory port arbiter.
package dmem_port_arbiter_pkg;

  localparam int MEM_ADDR_BUS = 32;
  localparam int MEM_DATA_BUS = 32;

  typedef enum logic {
    OWNER_M0 = 1'b0,
    OWNER_M1 = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

  localparam logic                    DISABLE      = 1'b0;
  localparam logic [MEM_DATA_BUS-1:0] DATA_INITIAL = '0;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// One requester's view of the shared data-memory port: request fields in, grant and read return out.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = dmem_port_arbiter_pkg::MEM_ADDR_BUS,
  parameter int DATA_W = dmem_port_arbiter_pkg::MEM_DATA_BUS
) ();

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        wea;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, wea, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, wea, output gnt, rvalid, rdata);

endinterface

// File: rtl/dmem_port_arbiter_rd_tag_pipe.sv
// RD_LAT-deep {valid, owner} shift register; the tail lines up with Data_in of the tagged read.
module dmem_port_arbiter_rd_tag_pipe
  import dmem_port_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push_vld,
  input  owner_e push_owner,
  output logic   tail_vld,
  output owner_e tail_owner
);

  rd_tag_t tag_q [RD_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0].valid <= push_vld;
      tag_q[0].owner <= push_vld ? push_owner : OWNER_M0;
      for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign tail_vld   = tag_q[RD_LAT-1].valid;
  assign tail_owner = tag_q[RD_LAT-1].owner;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-master arbiter for the single data-memory port: same-cycle grant and port drive,
// read data routed back to the issuing master RD_LAT cycles later.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = MEM_ADDR_BUS,
  parameter int DATA_W  = MEM_DATA_BUS,
  parameter int RD_LAT  = 1,
  parameter int RR_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  dmem_port_arbiter_if.slave m0,
  dmem_port_arbiter_if.slave m1,
  output logic              mem_w,
  output logic [ADDR_W-1:0] Addr_out,
  output logic [DATA_W-1:0] Data_out,
  output logic [3:0]        DWea,
  input  logic [DATA_W-1:0] Data_in
);

  owner_e            last_gnt;
  logic              gnt0, gnt1;
  logic              rd_push;
  owner_e            rd_owner;
  logic              tail_vld;
  owner_e            tail_owner;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  always_comb begin
    gnt0 = DISABLE;
    gnt1 = DISABLE;
    if (!rst) begin
      if (m0.req && m1.req) begin
        // Round-robin hands a tie to whichever master was not served last.
        if (RR_MODE == 0 || last_gnt == OWNER_M1) gnt0 = 1'b1;
        else                                      gnt1 = 1'b1;
      end else begin
        gnt0 = m0.req;
        gnt1 = m1.req;
      end
    end
  end

  always_comb begin
    mem_w    = DISABLE;
    Addr_out = '0;
    Data_out = DATA_INITIAL;
    DWea     = '0;
    if (gnt0) begin
      mem_w    = m0.we;
      Addr_out = m0.addr;
      Data_out = m0.wdata;
      DWea     = m0.we ? m0.wea : 4'b0000;
    end else if (gnt1) begin
      mem_w    = m1.we;
      Addr_out = m1.addr;
      Data_out = m1.wdata;
      DWea     = m1.we ? m1.wea : 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)       last_gnt <= OWNER_M0;
    else if (gnt0) last_gnt <= OWNER_M0;
    else if (gnt1) last_gnt <= OWNER_M1;
  end

  assign rd_push  = (gnt0 && !m0.we) || (gnt1 && !m1.we);
  assign rd_owner = gnt1 ? OWNER_M1 : OWNER_M0;

  dmem_port_arbiter_rd_tag_pipe #(.RD_LAT(RD_LAT)) u_rd_tag_pipe (
    .clk        (clk),
    .rst        (rst),
    .push_vld   (rd_push),
    .push_owner (rd_owner),
    .tail_vld   (tail_vld),
    .tail_owner (tail_owner)
  );

  assign rvalid0 = !rst && tail_vld && (tail_owner == OWNER_M0);
  assign rvalid1 = !rst && tail_vld && (tail_owner == OWNER_M1);

  // Data_in passes straight through on the return cycle; the register only holds it afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata0_q <= DATA_INITIAL;
      rdata1_q <= DATA_INITIAL;
    end else begin
      if (rvalid0) rdata0_q <= Data_in;
      if (rvalid1) rdata1_q <= Data_in;
    end
  end

  assign m0.gnt    = gnt0;
  assign m1.gnt    = gnt1;
  assign m0.rvalid = rvalid0;
  assign m1.rvalid = rvalid1;
  assign m0.rdata  = rvalid0 ? Data_in : rdata0_q;
  assign m1.rdata  = rvalid1 ? Data_in : rdata1_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench: fixed-priority DUT with RD_LAT=1, round-robin DUT with RD_LAT=3.
module tb_dmem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if_f0 ();
  dmem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if_f1 ();
  dmem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if_r0 ();
  dmem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if_r1 ();

  logic        mem_w_f, mem_w_r;
  logic [31:0] addr_f, addr_r, dout_f, dout_r;
  logic [3:0]  dwea_f, dwea_r;
  logic [31:0] din_f = '0;
  logic [31:0] din_r = '0;

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1), .RR_MODE(0)) u_fp (
    .clk(clk), .rst(rst), .m0(if_f0), .m1(if_f1),
    .mem_w(mem_w_f), .Addr_out(addr_f), .Data_out(dout_f), .DWea(dwea_f), .Data_in(din_f)
  );

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3), .RR_MODE(1)) u_rr (
    .clk(clk), .rst(rst), .m0(if_r0), .m1(if_r1),
    .mem_w(mem_w_r), .Addr_out(addr_r), .Data_out(dout_r), .DWea(dwea_r), .Data_in(din_r)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // idx: 0=fp.m0 1=fp.m1 2=rr.m0 3=rr.m1
  task automatic set_m(input int idx, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wea);
    case (idx)
      0: begin if_f0.req = req; if_f0.we = we; if_f0.addr = addr; if_f0.wdata = wdata; if_f0.wea = wea; end
      1: begin if_f1.req = req; if_f1.we = we; if_f1.addr = addr; if_f1.wdata = wdata; if_f1.wea = wea; end
      2: begin if_r0.req = req; if_r0.we = we; if_r0.addr = addr; if_r0.wdata = wdata; if_r0.wea = wea; end
      default: begin if_r1.req = req; if_r1.we = we; if_r1.addr = addr; if_r1.wdata = wdata; if_r1.wea = wea; end
    endcase
  endtask

  task automatic idle_all();
    for (int i = 0; i < 4; i++) set_m(i, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  // Inputs change 1ns after the edge, outputs are sampled 1ns later in the same cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_all();
    rst = 1'b1;
    tick();
    set_m(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    #1;
    check("gnt_in_reset", {62'd0, if_f0.gnt, if_f1.gnt}, 64'd0);
    tick();
    idle_all();
    rst = 1'b0;
    #1;
    check("reset_rvalid", {60'd0, if_f0.rvalid, if_f1.rvalid, if_r0.rvalid, if_r1.rvalid}, 64'd0);
    check("reset_rdata", {if_f0.rdata, if_r1.rdata}, 64'd0);
    check("reset_port", {27'd0, mem_w_f, dwea_f, addr_f}, 64'd0);

    // m0 read, RD_LAT=1
    tick();
    set_m(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    #1;
    check("rd_gnt", {62'd0, if_f0.gnt, if_f1.gnt}, 64'd2);
    check("rd_port", {31'd0, mem_w_f, addr_f}, 64'h100);
    tick();
    idle_all();
    din_f = 32'hDEADBEEF;
    #1;
    check("rd_rvalid", {62'd0, if_f0.rvalid, if_f1.rvalid}, 64'd2);
    check("rd_rdata", {32'd0, if_f0.rdata}, 64'hDEADBEEF);
    tick();
    din_f = 32'h0;
    #1;
    check("rd_rvalid_off", {62'd0, if_f0.rvalid, if_f1.rvalid}, 64'd0);
    check("rd_rdata_hold", {32'd0, if_f0.rdata}, 64'hDEADBEEF);

    // read with byte enables set must not write
    tick();
    set_m(0, 1'b1, 1'b0, 32'h200, 32'hFFFF_FFFF, 4'hF);
    #1;
    check("rd_mask", {59'd0, mem_w_f, dwea_f}, 64'd0);
    tick();
    idle_all();
    din_f = 32'h5555_AAAA;
    #1;
    check("mask_rdata", {31'd0, if_f0.rvalid, if_f0.rdata}, 64'h1_5555_AAAA);

    // m1 write
    tick();
    din_f = 32'h0;
    set_m(1, 1'b1, 1'b1, 32'h40, 32'h12345678, 4'b0011);
    #1;
    check("wr_gnt", {62'd0, if_f0.gnt, if_f1.gnt}, 64'd1);
    check("wr_port", {27'd0, mem_w_f, dwea_f, addr_f}, {27'd0, 1'b1, 4'b0011, 32'h40});
    check("wr_data", {32'd0, dout_f}, 64'h12345678);
    tick();
    idle_all();
    #1;
    check("wr_no_rvalid", {62'd0, if_f0.rvalid, if_f1.rvalid}, 64'd0);

    // fixed priority under constant contention
    for (int c = 0; c < 4; c++) begin
      tick();
      set_m(0, 1'b1, 1'b1, 32'h10 + c, 32'hA0 + c, 4'hF);
      set_m(1, 1'b1, 1'b1, 32'h80 + c, 32'hB0 + c, 4'hF);
      #1;
      check($sformatf("fp_tie%0d", c), {62'd0, if_f0.gnt, if_f1.gnt}, 64'd2);
      check($sformatf("fp_tie_addr%0d", c), {32'd0, addr_f}, 64'h10 + c);
    end
    tick();
    idle_all();
    #1;
    check("no_gnt_port", {27'd0, mem_w_f, dwea_f, addr_f}, 64'd0);
    check("no_gnt_data", {32'd0, dout_f}, 64'd0);

    // round-robin alternation from reset: m1, m0, m1, m0
    for (int c = 0; c < 4; c++) begin
      tick();
      set_m(2, 1'b1, 1'b1, 32'h10, 32'h1, 4'hF);
      set_m(3, 1'b1, 1'b1, 32'h20, 32'h2, 4'hF);
      #1;
      check($sformatf("rr_tie%0d", c), {62'd0, if_r0.gnt, if_r1.gnt}, (c % 2 == 0) ? 64'd1 : 64'd2);
    end

    // interleaved reads m0, m1, m0 with RD_LAT=3
    tick();
    set_m(2, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    set_m(3, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    check("il_g0", {62'd0, if_r0.gnt, if_r1.gnt}, 64'd2);
    tick();
    set_m(2, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_m(3, 1'b1, 1'b0, 32'h104, 32'h0, 4'h0);
    #1;
    check("il_g1", {62'd0, if_r0.gnt, if_r1.gnt}, 64'd1);
    tick();
    set_m(2, 1'b1, 1'b0, 32'h108, 32'h0, 4'h0);
    set_m(3, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    check("il_g2", {62'd0, if_r0.gnt, if_r1.gnt}, 64'd2);
    check("il_early", {62'd0, if_r0.rvalid, if_r1.rvalid}, 64'd0);
    tick();
    idle_all();
    din_r = 32'hA1A1_0001;
    #1;
    check("il_c3_vld", {62'd0, if_r0.rvalid, if_r1.rvalid}, 64'd2);
    check("il_c3_dat", {32'd0, if_r0.rdata}, 64'hA1A1_0001);
    tick();
    din_r = 32'hB2B2_0002;
    #1;
    check("il_c4_vld", {62'd0, if_r0.rvalid, if_r1.rvalid}, 64'd1);
    check("il_c4_dat", {if_r0.rdata, if_r1.rdata}, {32'hA1A1_0001, 32'hB2B2_0002});
    tick();
    din_r = 32'hC3C3_0003;
    #1;
    check("il_c5_vld", {62'd0, if_r0.rvalid, if_r1.rvalid}, 64'd2);
    check("il_c5_dat", {32'd0, if_r0.rdata}, 64'hC3C3_0003);
    tick();
    din_r = 32'h0;
    #1;
    check("il_c6_vld", {62'd0, if_r0.rvalid, if_r1.rvalid}, 64'd0);

    // m1 read in flight, reset one cycle later: never returns, rdata cleared, next tie to m1
    tick();
    set_m(3, 1'b1, 1'b0, 32'h300, 32'h0, 4'h0);
    #1;
    check("rst_rd_gnt", {62'd0, if_r0.gnt, if_r1.gnt}, 64'd1);
    tick();
    idle_all();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      din_r = 32'hEE00_0000 + c;
      #1;
      check($sformatf("rst_no_rvalid%0d", c), {62'd0, if_r0.rvalid, if_r1.rvalid}, 64'd0);
      tick();
    end
    din_r = 32'h0;
    check("rst_rdata", {if_r0.rdata, if_r1.rdata}, 64'd0);
    check("rst_port", {27'd0, mem_w_r, dwea_r, addr_r}, 64'd0);
    set_m(2, 1'b1, 1'b1, 32'h10, 32'h1, 4'hF);
    set_m(3, 1'b1, 1'b1, 32'h20, 32'h2, 4'hF);
    #1;
    check("rst_first_tie", {62'd0, if_r0.gnt, if_r1.gnt}, 64'd1);
    tick();
    idle_all();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
